// File: rtl/alu_ctrl_sequencer.sv
// alu_ctrl_sequencer: multi-cycle control unit issuing opcodes and controls to the datapath ALU.
// Accepts one instruction at a time over a valid/ready handshake and walks it through
// FETCH -> EXEC -> (MEM) -> FETCH. Optional retire counter enabled by ALU_CTRL_RETIRE_CNT_EN.
module alu_ctrl_sequencer #(
  parameter int unsigned IW = 9,
  parameter int unsigned W  = 8
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic [IW-1:0] Instr,
  input  logic          Instr_valid,
  output logic          Instr_ready,
  output logic [2:0]    Alu_op,
  input  logic          Alu_zero,
  output logic [2:0]    Rf_ra,
  output logic [2:0]    Rf_rb,
  output logic          Rf_we,
  output logic          Wb_sel,
  output logic          Mem_req,
  output logic          Mem_we,
  input  logic          Mem_ack,
  output logic          Pc_branch,
  output logic [W-1:0]  Pc_offset,
  output logic          Done
`ifdef ALU_CTRL_RETIRE_CNT_EN
  ,
  output logic [15:0]   Retire_cnt
`endif
);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StExec,
    StMem,
    StHalt
  } state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] ir_q, ir_d;
  logic          z_q, z_d;

  // Operand fields and branch offset come straight from IR in every state.
  assign Rf_ra     = ir_q[5:3];
  assign Rf_rb     = ir_q[2:0];
  assign Pc_offset = {{(W-6){ir_q[5]}}, ir_q[5:0]};

  // State, instruction register and zero flag.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= StIdle;
      ir_q    <= '0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      z_q     <= z_d;
    end
  end

  // Next-state decode and all control outputs.
  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    z_d         = z_q;
    Instr_ready = 1'b0;
    Alu_op      = ir_q[8] ? 3'b000 : {1'b0, ir_q[7:6]};
    Rf_we       = 1'b0;
    Wb_sel      = 1'b0;
    Mem_req     = 1'b0;
    Mem_we      = 1'b0;
    Pc_branch   = 1'b0;
    Done        = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (Start) state_d = StFetch;
      end
      StFetch: begin
        Instr_ready = 1'b1;
        if (Instr_valid) begin
          ir_d    = Instr;
          state_d = StExec;
        end
      end
      StExec: begin
        if (!ir_q[8]) begin
          // ALU op: write ALU result and capture Zero for a later BZ.
          Rf_we   = 1'b1;
          z_d     = Alu_zero;
          state_d = StFetch;
        end else begin
          unique case (ir_q[7:6])
            2'b00, 2'b01: state_d = StMem;
            2'b10: begin
              Pc_branch = z_q;
              state_d   = StFetch;
            end
            default: state_d = StHalt;
          endcase
        end
      end
      StMem: begin
        // IR[6] distinguishes STR (1) from LDR (0).
        Mem_req = 1'b1;
        Mem_we  = ir_q[6];
        if (Mem_ack) begin
          Rf_we   = ~ir_q[6];
          Wb_sel  = ~ir_q[6];
          state_d = StFetch;
        end
      end
      StHalt: begin
        Done = 1'b1;
        if (Start) state_d = StFetch;
      end
      default: state_d = StIdle;
    endcase
  end

`ifdef ALU_CTRL_RETIRE_CNT_EN
  logic        start_acc;
  logic        retire;
  logic [15:0] retire_cnt_q;

  assign start_acc  = Start && ((state_q == StIdle) || (state_q == StHalt));
  assign retire     = ((state_q == StExec) && (state_d == StFetch)) ||
                      ((state_q == StMem) && Mem_ack);
  assign Retire_cnt = retire_cnt_q;

  // Retired-instruction counter; wraps naturally at 16 bits.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      retire_cnt_q <= '0;
    end else if (start_acc) begin
      retire_cnt_q <= '0;
    end else if (retire) begin
      retire_cnt_q <= retire_cnt_q + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_ctrl_sequencer.sv
// Testbench for alu_ctrl_sequencer: directed scenarios plus a randomized instruction stream
// checked against an instruction-level reference model (zero flag and retire count).
`timescale 1ns/1ps
module tb_alu_ctrl_sequencer;
  localparam int IW = 9;
  localparam int W  = 8;

  logic          Clk = 1'b0;
  logic          Reset, Start, Instr_valid, Alu_zero, Mem_ack;
  logic [IW-1:0] Instr;
  logic          Instr_ready, Rf_we, Wb_sel, Mem_req, Mem_we, Pc_branch, Done;
  logic [2:0]    Alu_op, Rf_ra, Rf_rb;
  logic [W-1:0]  Pc_offset;
`ifdef ALU_CTRL_RETIRE_CNT_EN
  logic [15:0]   Retire_cnt;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state.
  bit          m_z;
  int unsigned m_cnt;

  // Observations captured by run_instr.
  logic       o_fetch_ready;
  logic [2:0] o_alu_op, o_ra, o_rb;
  logic [7:0] o_off;
  logic       o_rf_we, o_wb_sel, o_branch, o_done, o_req;
  int         o_mem_cycles;
  logic       o_we_all, o_we_any, o_wait_wr, o_ack_rfwe, o_ack_wbsel;
  logic       o_after_ready, o_after_done, o_after_req;

  always #5 Clk = ~Clk;

  alu_ctrl_sequencer #(.IW(IW), .W(W)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Start       (Start),
    .Instr       (Instr),
    .Instr_valid (Instr_valid),
    .Instr_ready (Instr_ready),
    .Alu_op      (Alu_op),
    .Alu_zero    (Alu_zero),
    .Rf_ra       (Rf_ra),
    .Rf_rb       (Rf_rb),
    .Rf_we       (Rf_we),
    .Wb_sel      (Wb_sel),
    .Mem_req     (Mem_req),
    .Mem_we      (Mem_we),
    .Mem_ack     (Mem_ack),
    .Pc_branch   (Pc_branch),
    .Pc_offset   (Pc_offset),
    .Done        (Done)
`ifdef ALU_CTRL_RETIRE_CNT_EN
    ,
    .Retire_cnt  (Retire_cnt)
`endif
  );

  task automatic next_cycle();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  // Drives one instruction from FETCH to its completion; records what the DUT did.
  task automatic run_instr(input logic [8:0] ins, input bit zero, input int wait_n);
    Instr = ins; Instr_valid = 1'b1;
    #1 o_fetch_ready = Instr_ready;
    next_cycle();
    Instr_valid = 1'b0; Instr = 9'($urandom); Alu_zero = zero;
    Mem_ack = 1'($urandom_range(0, 1));
    #1;
    o_alu_op = Alu_op; o_ra = Rf_ra; o_rb = Rf_rb; o_off = Pc_offset; o_rf_we = Rf_we;
    o_wb_sel = Wb_sel; o_branch = Pc_branch; o_done = Done; o_req = Mem_req;
    next_cycle();
    Alu_zero = 1'($urandom_range(0, 1));
    o_mem_cycles = 0; o_we_all = 1'b1; o_we_any = 1'b0; o_wait_wr = 1'b0;
    o_ack_rfwe = 1'b0; o_ack_wbsel = 1'b0;
    if (ins[8:7] == 2'b10) begin
      for (int k = 0; k <= wait_n; k++) begin
        Mem_ack = (k == wait_n);
        #1;
        if (Mem_req) o_mem_cycles++;
        o_we_all = o_we_all & Mem_we;
        o_we_any = o_we_any | Mem_we;
        if (k < wait_n) o_wait_wr = o_wait_wr | Rf_we | Wb_sel;
        else begin o_ack_rfwe = Rf_we; o_ack_wbsel = Wb_sel; end
        next_cycle();
      end
    end
    Mem_ack = 1'b0;
    #1;
    o_after_ready = Instr_ready; o_after_done = Done; o_after_req = Mem_req;
  endtask

  task automatic test_reset();
    Reset = 1'b1; Start = 1'b0; Instr_valid = 1'b0; Instr = '0; Alu_zero = 1'b0; Mem_ack = 1'b0;
    #2 Reset = 1'b0;
    m_z = 1'b0; m_cnt = 0;
    @(negedge Clk); @(negedge Clk); #1;
    n_chk++; if (Instr_ready !== 1'b0) $display("FAIL rst_ready got %b exp 0", Instr_ready); else n_pass++;
    n_chk++; if (Alu_op !== 3'd0) $display("FAIL rst_alu_op got %0d exp 0", Alu_op); else n_pass++;
    n_chk++; if ({Rf_ra, Rf_rb} !== 6'd0) $display("FAIL rst_rf_addr got %0d/%0d exp 0/0", Rf_ra, Rf_rb); else n_pass++;
    n_chk++; if (Pc_offset !== 8'd0) $display("FAIL rst_offset got %h exp 00", Pc_offset); else n_pass++;
    n_chk++; if ({Rf_we, Wb_sel, Mem_req, Mem_we, Pc_branch, Done} !== 6'd0)
      $display("FAIL rst_ctrl got %b exp 000000", {Rf_we, Wb_sel, Mem_req, Mem_we, Pc_branch, Done});
    else n_pass++;
`ifdef ALU_CTRL_RETIRE_CNT_EN
    n_chk++; if (Retire_cnt !== 16'd0) $display("FAIL rst_retire got %0d exp 0", Retire_cnt); else n_pass++;
`endif
    Reset = 1'b1;
  endtask

  task automatic test_idle_valid();
    logic any_ready;
    any_ready = 1'b0;
    Instr = 9'b001_010_011; Instr_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      next_cycle(); #1 any_ready = any_ready | Instr_ready;
    end
    n_chk++; if (any_ready !== 1'b0) $display("FAIL idle_ready got %b exp 0", any_ready); else n_pass++;
    n_chk++; if (Rf_ra !== 3'd0) $display("FAIL idle_not_accepted ra got %0d exp 0", Rf_ra); else n_pass++;
    Instr_valid = 1'b0; Start = 1'b1;
    next_cycle();
    Start = 1'b0; m_cnt = 0;
    #1;
    n_chk++; if (Instr_ready !== 1'b1) $display("FAIL start_ready got %b exp 1", Instr_ready); else n_pass++;
  endtask

  task automatic test_xor();
    run_instr(9'b001_010_011, 1'b0, 0);
    m_z = 1'b0; m_cnt++;
    n_chk++; if (o_alu_op !== 3'b001) $display("FAIL xor_alu_op got %b exp 001", o_alu_op); else n_pass++;
    n_chk++; if ({o_ra, o_rb} !== {3'd2, 3'd3}) $display("FAIL xor_ra_rb got %0d/%0d exp 2/3", o_ra, o_rb); else n_pass++;
    n_chk++; if ({o_rf_we, o_wb_sel} !== 2'b10) $display("FAIL xor_we_sel got %b exp 10", {o_rf_we, o_wb_sel}); else n_pass++;
    n_chk++; if (o_after_ready !== 1'b1) $display("FAIL xor_next_ready got %b exp 1", o_after_ready); else n_pass++;
  endtask

  task automatic test_branch();
    run_instr(9'b000_001_001, 1'b1, 0); m_z = 1'b1; m_cnt++;
    run_instr({3'b110, 6'b111110}, 1'b0, 0); m_cnt++;
    n_chk++; if (o_branch !== 1'b1) $display("FAIL bz_taken got %b exp 1", o_branch); else n_pass++;
    n_chk++; if (o_off !== 8'hFE) $display("FAIL bz_offset got %h exp FE", o_off); else n_pass++;
    n_chk++; if (o_rf_we !== 1'b0) $display("FAIL bz_no_write got %b exp 0", o_rf_we); else n_pass++;
    run_instr(9'b000_011_100, 1'b0, 0); m_z = 1'b0; m_cnt++;
    run_instr({3'b110, 6'b000101}, 1'b1, 0); m_cnt++;
    n_chk++; if (o_branch !== 1'b0) $display("FAIL bz_not_taken got %b exp 0", o_branch); else n_pass++;
    n_chk++; if (o_off !== 8'h05) $display("FAIL bz_offset_pos got %h exp 05", o_off); else n_pass++;
  endtask

  task automatic test_mem();
    run_instr(9'b100_001_010, 1'b0, 3); m_cnt++;
    n_chk++; if (o_mem_cycles != 4) $display("FAIL ldr_req_cycles got %0d exp 4", o_mem_cycles); else n_pass++;
    n_chk++; if (o_we_any !== 1'b0) $display("FAIL ldr_mem_we got %b exp 0", o_we_any); else n_pass++;
    n_chk++; if (o_wait_wr !== 1'b0) $display("FAIL ldr_early_write got %b exp 0", o_wait_wr); else n_pass++;
    n_chk++; if ({o_ack_rfwe, o_ack_wbsel} !== 2'b11) $display("FAIL ldr_ack_write got %b exp 11", {o_ack_rfwe, o_ack_wbsel}); else n_pass++;
    n_chk++; if ({o_after_req, o_after_ready} !== 2'b01) $display("FAIL ldr_after got %b exp 01", {o_after_req, o_after_ready}); else n_pass++;
    run_instr(9'b101_110_111, 1'b0, 0); m_cnt++;
    n_chk++; if (o_mem_cycles != 1) $display("FAIL str_req_cycles got %0d exp 1", o_mem_cycles); else n_pass++;
    n_chk++; if (o_we_all !== 1'b1) $display("FAIL str_mem_we got %b exp 1", o_we_all); else n_pass++;
    n_chk++; if (o_ack_rfwe !== 1'b0) $display("FAIL str_no_write got %b exp 0", o_ack_rfwe); else n_pass++;
  endtask

  task automatic test_halt();
    logic any_ready, all_done;
    run_instr(9'b010_000_000, 1'b1, 0); m_z = 1'b1; m_cnt++;
    run_instr(9'b111_000_000, 1'b0, 0);
    n_chk++; if ({o_after_done, o_after_ready} !== 2'b10) $display("FAIL halt_done got %b exp 10", {o_after_done, o_after_ready}); else n_pass++;
    any_ready = 1'b0; all_done = 1'b1;
    Instr = 9'b011_101_101; Instr_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      next_cycle(); #1;
      any_ready = any_ready | Instr_ready | Rf_we | Pc_branch;
      all_done  = all_done & Done;
    end
    n_chk++; if ({all_done, any_ready} !== 2'b10) $display("FAIL halt_hold got %b exp 10", {all_done, any_ready}); else n_pass++;
    Instr_valid = 1'b0; Start = 1'b1;
    next_cycle();
    Start = 1'b0; m_cnt = 0;
    #1;
    n_chk++; if ({Done, Instr_ready} !== 2'b01) $display("FAIL halt_resume got %b exp 01", {Done, Instr_ready}); else n_pass++;
`ifdef ALU_CTRL_RETIRE_CNT_EN
    n_chk++; if (Retire_cnt !== 16'd0) $display("FAIL halt_retire_clr got %0d exp 0", Retire_cnt); else n_pass++;
`endif
    run_instr({3'b110, 6'b000011}, 1'b0, 0); m_cnt++;
    n_chk++; if (o_branch !== m_z) $display("FAIL halt_z_kept got %b exp %b", o_branch, m_z); else n_pass++;
  endtask

  task automatic test_random();
    logic [8:0] ins;
    logic [2:0] op, e_op;
    bit         zero;
    int         wn;
    for (int n = 0; n < 80; n++) begin
      ins = 9'($urandom); op = ins[8:6];
      zero = 1'($urandom_range(0, 1)); wn = $urandom_range(0, 3);
      run_instr(ins, zero, wn);
      e_op = op[2] ? 3'd0 : op;
      n_chk++; if (o_fetch_ready !== 1'b1) $display("FAIL rnd_fetch_ready i=%0d got %b exp 1", n, o_fetch_ready); else n_pass++;
      n_chk++; if (o_alu_op !== e_op) $display("FAIL rnd_alu_op i=%0d got %b exp %b", n, o_alu_op, e_op); else n_pass++;
      n_chk++; if ({o_ra, o_rb} !== ins[5:0]) $display("FAIL rnd_ra_rb i=%0d got %o exp %o", n, {o_ra, o_rb}, ins[5:0]); else n_pass++;
      n_chk++; if (o_off !== 8'($signed(ins[5:0]))) $display("FAIL rnd_offset i=%0d got %h exp %h", n, o_off, 8'($signed(ins[5:0]))); else n_pass++;
      n_chk++; if ({o_rf_we, o_wb_sel, o_branch, o_done, o_req} !== {op < 3'd4, 1'b0, (op == 3'd6) && m_z, 1'b0, 1'b0})
        $display("FAIL rnd_exec_ctrl i=%0d op=%0d got %b exp %b", n, op, {o_rf_we, o_wb_sel, o_branch, o_done, o_req},
                 {op < 3'd4, 1'b0, (op == 3'd6) && m_z, 1'b0, 1'b0});
      else n_pass++;
      if (op < 3'd4) m_z = zero;
      if (op == 3'd4 || op == 3'd5) begin
        n_chk++; if (o_mem_cycles != wn + 1) $display("FAIL rnd_req_cycles i=%0d got %0d exp %0d", n, o_mem_cycles, wn + 1); else n_pass++;
        n_chk++; if ({o_we_all, o_we_any} !== {2{op == 3'd5}}) $display("FAIL rnd_mem_we i=%0d got %b exp %b", n, {o_we_all, o_we_any}, {2{op == 3'd5}}); else n_pass++;
        n_chk++; if ({o_wait_wr, o_ack_rfwe, o_ack_wbsel} !== {1'b0, {2{op == 3'd4}}})
          $display("FAIL rnd_mem_write i=%0d got %b exp %b", n, {o_wait_wr, o_ack_rfwe, o_ack_wbsel}, {1'b0, {2{op == 3'd4}}});
        else n_pass++;
      end
      if (op != 3'd7) m_cnt++;
      n_chk++; if ({o_after_ready, o_after_done, o_after_req} !== {op != 3'd7, op == 3'd7, 1'b0})
        $display("FAIL rnd_after i=%0d got %b exp %b", n, {o_after_ready, o_after_done, o_after_req}, {op != 3'd7, op == 3'd7, 1'b0});
      else n_pass++;
`ifdef ALU_CTRL_RETIRE_CNT_EN
      n_chk++; if (Retire_cnt !== m_cnt[15:0]) $display("FAIL rnd_retire i=%0d got %0d exp %0d", n, Retire_cnt, m_cnt[15:0]); else n_pass++;
`endif
      if (op == 3'd7) begin
        Start = 1'b1; next_cycle(); Start = 1'b0; m_cnt = 0; #1;
      end
    end
  endtask

  task automatic test_reset_mid_mem();
    Instr = 9'b100_000_001; Instr_valid = 1'b1;
    next_cycle();
    Instr_valid = 1'b0;
    next_cycle();
    Mem_ack = 1'b0;
    #1;
    n_chk++; if (Mem_req !== 1'b1) $display("FAIL midmem_req got %b exp 1", Mem_req); else n_pass++;
    #2 Reset = 1'b0;
    #1;
    n_chk++; if ({Mem_req, Done, Instr_ready, Rf_ra} !== 6'd0)
      $display("FAIL midmem_async got %b exp 000000", {Mem_req, Done, Instr_ready, Rf_ra});
    else n_pass++;
    m_z = 1'b0; m_cnt = 0;
    @(negedge Clk);
    Reset = 1'b1; Start = 1'b1;
    next_cycle();
    Start = 1'b0;
    #1;
    n_chk++; if (Instr_ready !== 1'b1) $display("FAIL midmem_restart got %b exp 1", Instr_ready); else n_pass++;
  endtask

`ifdef ALU_CTRL_RETIRE_CNT_EN
  task automatic test_retire();
    for (int i = 0; i < 5; i++) run_instr({1'b0, 8'($urandom)}, 1'b0, 0);
    run_instr(9'b100_010_010, 1'b0, 2);
    run_instr(9'b111_000_000, 1'b0, 0);
    n_chk++; if (Retire_cnt !== 16'd6) $display("FAIL retire_count got %0d exp 6", Retire_cnt); else n_pass++;
    Start = 1'b1; next_cycle(); Start = 1'b0; #1;
    n_chk++; if (Retire_cnt !== 16'd0) $display("FAIL retire_clear got %0d exp 0", Retire_cnt); else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_idle_valid();
    test_xor();
    test_branch();
    test_mem();
    test_halt();
    test_random();
    test_reset_mid_mem();
`ifdef ALU_CTRL_RETIRE_CNT_EN
    test_retire();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
